mem_arbiter: RTL and testbench

Two-port arbiter that shares one single-ported memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined core. Each requester holds a request until it receives a one-cycle `valid` response. The arbiter serialises transactions onto a downstream req/ready memory bus with variable wait states. It also runs a watchdog that aborts transactions the memory never completes.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the instruction-fetch
// requester and the data requester, serialising transactions onto a req/ready
// bus. A watchdog aborts any transaction the memory never completes.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// between simultaneous requests (default is fixed priority, data over fetch).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wstrb,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  // downstream memory bus
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  // one memory command, registered at grant time and held until completion
  typedef struct packed {
    logic              we;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  localparam int             CW      = 16;
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  TO_MAX  = CW'(TIMEOUT);

  state_t         state;
  mreq_t          m_q;
  mreq_t          f_pkt;
  mreq_t          d_pkt;
  logic [CW-1:0]  cnt;
  logic           grant_d;

  assign m_we    = m_q.we;
  assign m_wstrb = m_q.wstrb;
  assign m_addr  = m_q.addr;
  assign m_wdata = m_q.wdata;

  // candidate commands for each requester; fetches never write
  always_comb begin
    f_pkt       = '0;
    f_pkt.addr  = if_addr;
    d_pkt       = '0;
    d_pkt.we    = d_we;
    d_pkt.wstrb = d_we ? d_wstrb : 4'b0;
    d_pkt.addr  = d_addr;
    d_pkt.wdata = d_wdata;
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // remember who was granted last; aborted grants count as served
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_d <= 1'b0;
    else if (state == IDLE && (if_req || d_req))
      last_d <= grant_d;
  end

  // on a tie the requester not served last wins; a lone requester always wins
  assign grant_d = d_req && (!if_req || !last_d);
`else
  // fixed priority: data beats fetch
  assign grant_d = d_req;
`endif

  // main FSM: grant in IDLE, hold the bus in BUSY_x, one-cycle response in RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      m_q      <= '0;
      m_req    <= 1'b0;
      cnt      <= '0;
      if_rdata <= '0;
      if_valid <= 1'b0;
      d_rdata  <= '0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            m_req <= 1'b1;
            cnt   <= '0;
            if (grant_d) begin
              state <= BUSY_D;
              m_q   <= d_pkt;
            end else begin
              state <= BUSY_IF;
              m_q   <= f_pkt;
            end
          end
        end

        BUSY_IF, BUSY_D: begin
          if (m_req) begin
            // m_ready only matters while the request is on the bus
            if (m_ready) begin
              m_req <= 1'b0;
              state <= RESP;
              if (state == BUSY_IF) begin
                if_valid <= 1'b1;
                if_rdata <= m_rdata;
              end else begin
                d_valid <= 1'b1;
                if (!m_q.we)
                  d_rdata <= m_rdata;
              end
            end else if (cnt == TO_LAST) begin
              // watchdog expired: withdraw the request, report next cycle
              m_req <= 1'b0;
              cnt   <= TO_MAX;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            // request already withdrawn by the watchdog: abort with zero data
            err   <= 1'b1;
            state <= RESP;
            if (state == BUSY_IF) begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= '0;
            end
          end
        end

        RESP: begin
          // requesters drop their req here, so nothing is sampled this cycle
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a scoreboard for grants and
// responses, plus hand-written timeout and mid-transaction reset sequences.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_wstrb = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          m_req;
  logic          m_we;
  logic [3:0]    m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          err;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          f_en;
    logic [31:0] f_addr;
    bit          d_en;
    bit          d_we;
    logic [3:0]  d_strb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          waits;
    bit          d_first;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          chk_strb;
    bit          chk_wdata;
    int          exp_len;   // expected m_req high cycles, 0 = don't check
  } grant_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     mem_waits = 0;
  bit     tie0 = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  bit     last_d_m = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  // memory model: answers after mem_waits wait states unless tied off
  initial begin : responder
    int wc;
    wc = 0;
    forever begin
      @(negedge clk);
      if (m_req && !tie0) begin
        if (wc >= mem_waits) begin
          m_ready = 1'b1;
          m_rdata = mem_fn(m_addr);
        end else begin
          m_ready = 1'b0;
          wc++;
        end
      end else begin
        m_ready = 1'b0;
        wc = 0;
      end
    end
  end

  // bus and response monitor: pops scoreboard entries as the DUT produces them
  initial begin : monitor
    grant_t        cur;
    resp_t         r;
    bit            prev_m;
    int            hi_len;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [3:0]    s_strb;
    logic [DW-1:0] s_wdata;
    prev_m = 1'b0;
    hi_len = 0;
    cur = '{32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 0};
    forever begin
      @(negedge clk);
      if (m_req && !prev_m) begin
        if (gq.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexp: got m_req=1 at addr %h want no grant", m_addr);
        end else begin
          cur = gq.pop_front();
          chk("m_addr", m_addr, cur.addr);
          chk("m_we", 32'(m_we), 32'(cur.we));
          if (cur.chk_strb)  chk("m_wstrb", 32'(m_wstrb), 32'(cur.strb));
          if (cur.chk_wdata) chk("m_wdata", m_wdata, cur.wdata);
        end
        s_addr = m_addr; s_we = m_we; s_strb = m_wstrb; s_wdata = m_wdata;
        hi_len = 1;
      end else if (m_req) begin
        chk("m_hold", 32'(m_addr === s_addr && m_we === s_we &&
                          m_wstrb === s_strb && m_wdata === s_wdata), 32'd1);
        hi_len++;
      end else if (prev_m && cur.exp_len != 0) begin
        chk("m_req_len", hi_len, cur.exp_len);
      end
      prev_m = m_req;

      if (if_valid) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexp: got if_valid=1 want none");
        end else begin
          r = rq.pop_front();
          chk("resp_port_if", 32'(r.is_d), 32'd0);
          chk("if_rdata", if_rdata, r.rdata);
          chk("if_err", 32'(err), 32'(r.err));
        end
      end
      if (d_valid) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexp: got d_valid=1 want none");
        end else begin
          r = rq.pop_front();
          chk("resp_port_d", 32'(r.is_d), 32'd1);
          chk("d_rdata", d_rdata, r.rdata);
          chk("d_err", 32'(err), 32'(r.err));
        end
      end
      if (err && !if_valid && !d_valid) begin
        total++; bad++;
        $display("FAIL err_alone: got err=1 without valid want err with valid");
      end
    end
  end

  function automatic vec_t mk(input bit f_en, input logic [31:0] f_addr, input bit d_en,
                              input bit d_we_i, input logic [3:0] strb, input logic [31:0] da,
                              input logic [31:0] dw, input int waits, input bit d_first,
                              input logic [31:0] exp_if, input logic [31:0] exp_d);
    vec_t v;
    v.f_en = f_en; v.f_addr = f_addr; v.d_en = d_en; v.d_we = d_we_i; v.d_strb = strb;
    v.d_addr = da; v.d_wdata = dw; v.waits = waits; v.d_first = d_first;
    v.exp_if = exp_if; v.exp_d = exp_d;
    return v;
  endfunction

  // drive one table row, push expectations in service order, check latencies
  task automatic run_vec(input vec_t v);
    bit     d_first;
    int     w, t0, lat_f, lat_d, l1, l2, lf_exp, ld_exp;
    grant_t g;
    resp_t  r;
    w = v.waits;
    d_first = v.d_en && (!v.f_en || v.d_first);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (v.d_en && v.f_en) d_first = !last_d_m;
`endif
    l1 = 2 + w;
    l2 = l1 + 3 + w;
    lf_exp = (v.d_en && d_first) ? l2 : l1;
    ld_exp = (v.f_en && !d_first) ? l2 : l1;
    for (int k = 0; k < 2; k++) begin
      bit is_d;
      is_d = (k == 0) ? d_first : !d_first;
      if (is_d ? v.d_en : v.f_en) begin
        if (is_d) begin
          g = '{v.d_addr, v.d_we, v.d_strb, v.d_wdata, v.d_we, v.d_we, w + 1};
          r = '{1'b1, v.exp_d, 1'b0};
        end else begin
          g = '{v.f_addr, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, w + 1};
          r = '{1'b0, v.exp_if, 1'b0};
        end
        gq.push_back(g);
        rq.push_back(r);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_m = is_d;
`endif
      end
    end
    @(negedge clk);
    mem_waits = w;
    if_req = v.f_en; if_addr = v.f_addr;
    d_req = v.d_en; d_we = v.d_we; d_wstrb = v.d_strb; d_addr = v.d_addr; d_wdata = v.d_wdata;
    t0 = cyc; lat_f = -1; lat_d = -1;
    for (int n = 0; n < 40 && (if_req || d_req); n++) begin
      @(negedge clk);
      if (if_valid && if_req) begin lat_f = cyc - t0; if_req = 1'b0; end
      if (d_valid && d_req)   begin lat_d = cyc - t0; d_req = 1'b0; end
    end
    if (v.f_en) chk("lat_if", lat_f, lf_exp);
    if (v.d_en) chk("lat_d", lat_d, ld_exp);
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin : main
    vec_t tv[6];
    int   t0;
    tv[0] = mk(1, 32'h100,  0, 0, 4'h0, 32'h0,    32'h0,         0, 0, 32'h0000_0013, 32'h0);
    tv[1] = mk(0, 32'h0,    1, 1, 4'hF, 32'h2004, 32'hDEAD_BEEF, 3, 1, 32'h0,         32'h0);
    tv[2] = mk(0, 32'h0,    1, 0, 4'h0, 32'h40,   32'h0,         1, 1, 32'h0,         32'h0040_FFBF);
    tv[3] = mk(1, 32'h200,  1, 0, 4'h0, 32'h3000, 32'h0,         0, 1, 32'h0200_FDFF, 32'h3000_CFFF);
    tv[4] = mk(1, 32'h1234, 1, 1, 4'h3, 32'h44,   32'h1122_3344, 2, 1, 32'h1234_EDCB, 32'h3000_CFFF);
    tv[5] = mk(1, 32'h0ABC, 0, 0, 4'h0, 32'h0,    32'h0,         3, 0, 32'h0ABC_F543, 32'h0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_strb_we", 32'({m_we, m_wstrb}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // watchdog: memory never answers, m_req high TO cycles, err+valid at TO+2
    @(negedge clk);
    tie0 = 1'b1;
    gq.push_back('{32'h80, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, TO});
    rq.push_back('{1'b1, 32'h0, 1'b1});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    t0 = cyc;
    for (int k = 1; k <= TO + 2; k++) begin
      @(negedge clk);
      chk($sformatf("to_mreq_c%0d", cyc - t0), 32'(m_req), 32'(k <= TO));
      chk($sformatf("to_err_c%0d", cyc - t0), 32'(err), 32'(k == TO + 2));
    end
    chk("to_d_valid", 32'(d_valid), 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tie0 = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_m = 1'b1;
`endif

    // reset mid-transaction: m_req falls at once, no valid or err follows
    @(negedge clk);
    tie0 = 1'b1;
    gq.push_back('{32'h90, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 0});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    repeat (2) @(negedge clk);
    chk("rst_pre_mreq", 32'(m_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_mreq", 32'(m_req), 32'd0);
    chk("rst_async_if_rdata", if_rdata, 32'd0);
    chk("rst_async_m_addr", m_addr, 32'd0);
    d_req = 1'b0;
    tie0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_pulse", 32'(d_valid | if_valid | err), 32'd0);
    end
    reset = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_m = 1'b0;
`endif
    run_vec(mk(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0000_0013, 32'h0));

    repeat (2) @(negedge clk);
    chk("gq_empty", gq.size(), 32'd0);
    chk("rq_empty", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case something wedges outside the bounded loops
  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
